// File: rtl/video_timing_ctrl.sv
// Video timing controller: programmable raster (default 720x480p60) with
// registered sync/DE/coordinate outputs and one line-prefetch request per
// displayed line, issued in horizontal blanking with a req/ack handshake.
module video_timing_ctrl #(
  parameter int HDISP  = 720,
  parameter int HFP    = 16,
  parameter int HPULSE = 62,
  parameter int HBP    = 60,
  parameter int VDISP  = 480,
  parameter int VFP    = 9,
  parameter int VPULSE = 6,
  parameter int VBP    = 30,
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int XW     = $clog2(HDISP),
  localparam int YW     = $clog2(VDISP)
) (
  input  logic          fpga_CLK_AUX,
  input  logic          n_rst,
  input  logic          enable,
  output logic          vid_HS,
  output logic          vid_VS,
  output logic          vid_DE,
  output logic [XW-1:0] vid_X,
  output logic [YW-1:0] vid_Y,
  output logic          frame_start,
  output logic          line_req,
  output logic [YW-1:0] line_num,
  input  logic          line_ack,
  output logic          underrun
);

  localparam int HCW = $clog2(HTOTAL);
  localparam int VCW = $clog2(VTOTAL);

  localparam logic [HCW-1:0] H_DISP = HCW'(HDISP);
  localparam logic [HCW-1:0] H_SS   = HCW'(HDISP + HFP);
  localparam logic [HCW-1:0] H_SE   = HCW'(HDISP + HFP + HPULSE - 1);
  localparam logic [HCW-1:0] H_LAST = HCW'(HTOTAL - 1);
  localparam logic [VCW-1:0] V_DISP = VCW'(VDISP);
  localparam logic [VCW-1:0] V_DLST = VCW'(VDISP - 1);
  localparam logic [VCW-1:0] V_SS   = VCW'(VDISP + VFP);
  localparam logic [VCW-1:0] V_SE   = VCW'(VDISP + VFP + VPULSE - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(VTOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t         state;
  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           last_col;  // output-aligned: pins currently show column HTOTAL-1

  logic           h_end, v_end, run, start;
  logic           de_n, hs_n, vs_n, issue;
  logic [YW-1:0]  next_num;

  assign h_end = (hcnt == H_LAST);
  assign v_end = (vcnt == V_LAST);
  assign run   = (state != S_IDLE);
  assign start = (state == S_IDLE) && enable;

  // Counter decode, registered below so pins lag the counters by one cycle
  assign de_n     = (hcnt < H_DISP) && (vcnt < V_DISP);
  assign hs_n     = !((hcnt >= H_SS) && (hcnt <= H_SE));
  assign vs_n     = !((vcnt >= V_SS) && (vcnt <= V_SE));
  // Prefetch the next displayed line; the last raster line prefetches line 0
  assign issue    = (hcnt == H_DISP) && ((vcnt < V_DLST) || v_end);
  assign next_num = v_end ? '0 : YW'(vcnt + VCW'(1));

  // Run control: start/stop only take effect on frame boundaries
  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (enable) state <= S_RUN;
        S_RUN:   if (!enable) state <= S_DRAIN;
        S_DRAIN: begin
          if (enable)             state <= S_RUN;
          else if (h_end && v_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Raster counters: held at zero while idle, free-running otherwise
  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!run) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_end) begin
      hcnt <= '0;
      vcnt <= v_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Output registers, line request handshake and sticky underrun
  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      vid_HS      <= 1'b1;
      vid_VS      <= 1'b1;
      vid_DE      <= 1'b0;
      vid_X       <= '0;
      vid_Y       <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_num    <= '0;
      underrun    <= 1'b0;
      last_col    <= 1'b0;
    end else if (!run) begin
      vid_HS      <= 1'b1;
      vid_VS      <= 1'b1;
      vid_DE      <= 1'b0;
      vid_X       <= '0;
      vid_Y       <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_num    <= '0;
      last_col    <= 1'b0;
      if (start) underrun <= 1'b0;
    end else begin
      vid_HS      <= hs_n;
      vid_VS      <= vs_n;
      vid_DE      <= de_n;
      vid_X       <= de_n ? hcnt[XW-1:0] : '0;
      vid_Y       <= de_n ? vcnt[YW-1:0] : '0;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      last_col    <= h_end;
      // line_req lives in pin timing, so its deadline is the last pin column
      if (line_req) begin
        if (line_ack) begin
          line_req <= 1'b0;
        end else if (last_col) begin
          line_req <= 1'b0;
          underrun <= 1'b1;
        end
      end else if (issue) begin
        line_req <= 1'b1;
        line_num <= next_num;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a 15x8 (120-cycle) raster.
module tb_video_timing_ctrl;
  localparam int HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VDISP = 4, VFP = 1, VPULSE = 2, VBP = 1;
  localparam int XW = 3, YW = 2, HT = 15;

  logic clk = 1'b0;
  logic n_rst, enable, line_ack;
  logic vid_HS, vid_VS, vid_DE, frame_start, line_req, underrun;
  logic [XW-1:0] vid_X;
  logic [YW-1:0] vid_Y, line_num;

  int n_cmp = 0, n_err = 0;

  // captured output trace, index 0 = first active pixel of a frame
  logic          cap_de [0:255], cap_hs [0:255], cap_vs [0:255], cap_fs [0:255];
  logic          cap_rq [0:255], cap_ur [0:255];
  logic [XW-1:0] cap_x  [0:255];
  logic [YW-1:0] cap_y  [0:255], cap_num [0:255];

  // line_req pulses found in a trace
  int p_start [0:15], p_len [0:15], p_num [0:15];
  int n_p;
  // requested line per raster line, -1 = no request on that line
  int exp_num [0:7] = '{1, 2, 3, -1, -1, -1, -1, 0};

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .fpga_CLK_AUX(clk), .n_rst(n_rst), .enable(enable),
    .vid_HS(vid_HS), .vid_VS(vid_VS), .vid_DE(vid_DE),
    .vid_X(vid_X), .vid_Y(vid_Y), .frame_start(frame_start),
    .line_req(line_req), .line_num(line_num), .line_ack(line_ack),
    .underrun(underrun)
  );

  // Record n cycles at negedges. mode 0: ack low, 1: ack high, 2: ack 4 cycles after req rises
  task automatic capture(input int n, input int mode, input int drop_at);
    int age;
    logic prev;
    age = 0;
    prev = 1'b0;
    for (int c = 0; c < n; c++) begin
      cap_de[c] = vid_DE; cap_hs[c] = vid_HS; cap_vs[c] = vid_VS; cap_fs[c] = frame_start;
      cap_rq[c] = line_req; cap_ur[c] = underrun; cap_x[c] = vid_X; cap_y[c] = vid_Y;
      cap_num[c] = line_num;
      if (line_req) age = prev ? age + 1 : 0;
      prev = line_req;
      if (c == drop_at) enable = 1'b0;
      case (mode)
        0: line_ack = 1'b0;
        1: line_ack = 1'b1;
        default: line_ack = line_req && (age == 4);
      endcase
      @(negedge clk);
    end
  endtask

  task automatic find_pulses(input int n);
    n_p = 0;
    for (int c = 0; c < n; c++) begin
      if (cap_rq[c] && (c == 0 || !cap_rq[c-1]) && n_p < 16) begin
        p_start[n_p] = c;
        p_num[n_p] = int'(cap_num[c]);
        p_len[n_p] = 0;
        n_p++;
      end
      if (cap_rq[c] && n_p > 0) p_len[n_p-1]++;
    end
  endtask

  task automatic test_reset();
    int bad;
    n_rst = 1'b1; enable = 1'b0; line_ack = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    n_cmp++; if (vid_HS !== 1'b1) begin n_err++; $display("FAIL rst_hs: got %b expected 1", vid_HS); end
    n_cmp++; if (vid_VS !== 1'b1) begin n_err++; $display("FAIL rst_vs: got %b expected 1", vid_VS); end
    n_cmp++; if (vid_DE !== 1'b0) begin n_err++; $display("FAIL rst_de: got %b expected 0", vid_DE); end
    n_cmp++; if (vid_X !== 3'd0 || vid_Y !== 2'd0) begin n_err++; $display("FAIL rst_xy: got %0d,%0d expected 0,0", vid_X, vid_Y); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs: got %b expected 0", frame_start); end
    n_cmp++; if (line_req !== 1'b0 || line_num !== 2'd0) begin n_err++; $display("FAIL rst_req: got %b/%0d expected 0/0", line_req, line_num); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_ur: got %b expected 0", underrun); end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vid_HS !== 1'b1 || vid_VS !== 1'b1 || vid_DE !== 1'b0 || line_req !== 1'b0 ||
          underrun !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_raster();
    int fs_n, de_n, hs_n, vs_n, errs, h, v, ex;
    logic ede;
    line_ack = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL start_early: got %b expected 0", frame_start); end
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1 || vid_DE !== 1'b1 || vid_X !== 3'd0 || vid_Y !== 2'd0) begin
      n_err++; $display("FAIL start_pixel: got fs=%b de=%b x=%0d y=%0d expected 1 1 0 0", frame_start, vid_DE, vid_X, vid_Y);
    end
    capture(240, 1, -1);
    fs_n = 0; de_n = 0; hs_n = 0; vs_n = 0; errs = 0;
    for (int c = 0; c < 240; c++) begin
      fs_n += int'(cap_fs[c]); de_n += int'(cap_de[c]);
      hs_n += int'(!cap_hs[c]); vs_n += int'(!cap_vs[c]);
      h = c % HT; v = (c / HT) % 8;
      ede = (h < HDISP) && (v < VDISP);
      ex = ede ? h : 0;
      if (cap_de[c] !== ede || int'(cap_x[c]) !== ex || int'(cap_y[c]) !== (ede ? v : 0)) errs++;
    end
    n_cmp++; if (fs_n !== 2 || cap_fs[120] !== 1'b1) begin n_err++; $display("FAIL raster_fs: got %0d pulses (c120=%b) expected 2 (1)", fs_n, cap_fs[120]); end
    n_cmp++; if (de_n !== 64) begin n_err++; $display("FAIL raster_de: got %0d expected 64", de_n); end
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL raster_xy: got %0d bad cycles expected 0", errs); end
    n_cmp++; if ({cap_hs[9], cap_hs[10], cap_hs[12], cap_hs[13]} !== 4'b1001) begin
      n_err++; $display("FAIL raster_hs_edge: got %b%b%b%b expected 1001", cap_hs[9], cap_hs[10], cap_hs[12], cap_hs[13]);
    end
    n_cmp++; if (hs_n !== 48) begin n_err++; $display("FAIL raster_hs_len: got %0d expected 48", hs_n); end
    n_cmp++; if ({cap_vs[74], cap_vs[75], cap_vs[104], cap_vs[105]} !== 4'b1001) begin
      n_err++; $display("FAIL raster_vs_edge: got %b%b%b%b expected 1001", cap_vs[74], cap_vs[75], cap_vs[104], cap_vs[105]);
    end
    n_cmp++; if (vs_n !== 60) begin n_err++; $display("FAIL raster_vs_len: got %0d expected 60", vs_n); end
    find_pulses(240);
    n_cmp++; if (n_p !== 8) begin n_err++; $display("FAIL raster_req_cnt: got %0d expected 8", n_p); end
    for (int k = 0; k < n_p; k++) begin
      n_cmp++;
      if (p_start[k] % HT !== 8 || p_num[k] !== exp_num[(p_start[k] / HT) % 8] || p_len[k] !== 1) begin
        n_err++; $display("FAIL raster_req%0d: got start=%0d num=%0d len=%0d expected col 8 num %0d len 1",
                          k, p_start[k], p_num[k], p_len[k], exp_num[(p_start[k] / HT) % 8]);
      end
    end
  endtask

  task automatic test_handshake();
    int ur_n;
    capture(240, 2, -1);
    find_pulses(240);
    ur_n = 0;
    for (int c = 0; c < 240; c++) ur_n += int'(cap_ur[c]);
    n_cmp++; if (n_p !== 8) begin n_err++; $display("FAIL hs_req_cnt: got %0d expected 8", n_p); end
    for (int k = 0; k < n_p; k++) begin
      n_cmp++;
      if (p_start[k] % HT !== 8 || p_num[k] !== exp_num[(p_start[k] / HT) % 8] || p_len[k] !== 5) begin
        n_err++; $display("FAIL hs_req%0d: got start=%0d num=%0d len=%0d expected col 8 num %0d len 5",
                          k, p_start[k], p_num[k], p_len[k], exp_num[(p_start[k] / HT) % 8]);
      end
    end
    n_cmp++; if (ur_n !== 0) begin n_err++; $display("FAIL hs_underrun: got %0d cycles expected 0", ur_n); end
    n_cmp++; if (cap_fs[0] !== 1'b1 || cap_fs[120] !== 1'b1) begin n_err++; $display("FAIL hs_fs: got %b%b expected 11", cap_fs[0], cap_fs[120]); end
  endtask

  task automatic test_underrun();
    int ur_n, de_n, hs_n, vs_n, fs_n;
    capture(240, 0, -1);
    find_pulses(240);
    ur_n = 0; de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    for (int c = 0; c < 240; c++) begin
      if (c >= 15) ur_n += int'(cap_ur[c]);
      de_n += int'(cap_de[c]); hs_n += int'(!cap_hs[c]);
      vs_n += int'(!cap_vs[c]); fs_n += int'(cap_fs[c]);
    end
    n_cmp++; if (n_p !== 8) begin n_err++; $display("FAIL ur_req_cnt: got %0d expected 8", n_p); end
    for (int k = 0; k < n_p; k++) begin
      n_cmp++;
      if (p_start[k] % HT !== 8 || p_num[k] !== exp_num[(p_start[k] / HT) % 8] || p_len[k] !== 7) begin
        n_err++; $display("FAIL ur_req%0d: got start=%0d num=%0d len=%0d expected col 8 num %0d len 7",
                          k, p_start[k], p_num[k], p_len[k], exp_num[(p_start[k] / HT) % 8]);
      end
    end
    n_cmp++; if (cap_ur[14] !== 1'b0 || cap_ur[15] !== 1'b1) begin n_err++; $display("FAIL ur_set: got %b%b expected 01", cap_ur[14], cap_ur[15]); end
    n_cmp++; if (ur_n !== 225) begin n_err++; $display("FAIL ur_sticky: got %0d expected 225", ur_n); end
    n_cmp++; if (de_n !== 64 || hs_n !== 48 || vs_n !== 60 || fs_n !== 2) begin
      n_err++; $display("FAIL ur_timing: got de=%0d hs=%0d vs=%0d fs=%0d expected 64 48 60 2", de_n, hs_n, vs_n, fs_n);
    end
    enable = 1'b0;
    repeat (150) @(negedge clk);
    n_cmp++; if (vid_DE !== 1'b0 || vid_HS !== 1'b1 || vid_VS !== 1'b1 || line_req !== 1'b0) begin
      n_err++; $display("FAIL ur_idle: got de=%b hs=%b vs=%b req=%b expected 0 1 1 0", vid_DE, vid_HS, vid_VS, line_req);
    end
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_hold_idle: got %b expected 1", underrun); end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear: got %b expected 0", underrun); end
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL ur_restart: got %b expected 1", frame_start); end
  endtask

  task automatic test_stop_midframe();
    int de_n, fs_n, bad;
    capture(160, 1, 20);
    find_pulses(160);
    de_n = 0; fs_n = 0; bad = 0;
    for (int c = 0; c < 160; c++) begin
      de_n += int'(cap_de[c]); fs_n += int'(cap_fs[c]);
      if (c >= 120 && (cap_de[c] !== 1'b0 || cap_hs[c] !== 1'b1 || cap_vs[c] !== 1'b1 ||
                       cap_rq[c] !== 1'b0 || cap_ur[c] !== 1'b0)) bad++;
    end
    n_cmp++; if (de_n !== 32) begin n_err++; $display("FAIL stop_de: got %0d expected 32", de_n); end
    n_cmp++; if (cap_de[37] !== 1'b1 || cap_de[45] !== 1'b1 || cap_vs[80] !== 1'b0) begin
      n_err++; $display("FAIL stop_drain: got de37=%b de45=%b vs80=%b expected 1 1 0", cap_de[37], cap_de[45], cap_vs[80]);
    end
    n_cmp++; if (cap_hs[115] !== 1'b0 || cap_hs[130] !== 1'b1) begin n_err++; $display("FAIL stop_hs: got %b%b expected 01", cap_hs[115], cap_hs[130]); end
    n_cmp++; if (fs_n !== 1) begin n_err++; $display("FAIL stop_fs: got %0d expected 1", fs_n); end
    n_cmp++; if (n_p !== 4) begin n_err++; $display("FAIL stop_req_cnt: got %0d expected 4", n_p); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stop_idle: got %0d bad cycles expected 0", bad); end
    enable = 1'b1;
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL stop_restart_early: got %b expected 0", frame_start); end
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL stop_restart: got %b expected 1", frame_start); end
  endtask

  task automatic test_async_reset();
    int bad;
    capture(40, 0, -1);
    n_cmp++; if (line_req !== 1'b1 || vid_HS !== 1'b0 || underrun !== 1'b1 || line_num !== 2'd3) begin
      n_err++; $display("FAIL arst_pre: got req=%b hs=%b ur=%b num=%0d expected 1 0 1 3", line_req, vid_HS, underrun, line_num);
    end
    n_rst = 1'b0;
    enable = 1'b0;
    #1;
    n_cmp++; if (line_req !== 1'b0 || line_num !== 2'd0) begin n_err++; $display("FAIL arst_req: got %b/%0d expected 0/0", line_req, line_num); end
    n_cmp++; if (vid_HS !== 1'b1 || vid_VS !== 1'b1 || vid_DE !== 1'b0) begin
      n_err++; $display("FAIL arst_sync: got hs=%b vs=%b de=%b expected 1 1 0", vid_HS, vid_VS, vid_DE);
    end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL arst_ur: got %b expected 0", underrun); end
    @(negedge clk);
    n_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_start !== 1'b0 || vid_DE !== 1'b0 || line_req !== 1'b0 || vid_HS !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL arst_idle: got %0d bad cycles expected 0", bad); end
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (frame_start !== 1'b1 || vid_DE !== 1'b1) begin
      n_err++; $display("FAIL arst_restart: got fs=%b de=%b expected 1 1", frame_start, vid_DE);
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_handshake();
    test_underrun();
    test_stop_midframe();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Video timing controller for the 27 MHz video clock domain of the video display top level. It generates horizontal/vertical sync, display-enable and pixel coordinates for a programmable raster, defaulting to 720x480p60. It also sequences the frame-buffer datapath by issuing one line-prefetch request per displayed line during horizontal blanking, with a req/ack handshake and a sticky underrun flag.

## Interface
- HDISP, 720, active pixels per line
- HFP, 16, horizontal front porch (cycles)
- HPULSE, 62, horizontal sync width (cycles)
- HBP, 60, horizontal back porch (cycles)
- VDISP, 480, active lines per frame
- VFP, 9, vertical front porch (lines)
- VPULSE, 6, vertical sync width (lines)
- VBP, 30, vertical back porch (lines)
- Derived: HTOTAL=HDISP+HFP+HPULSE+HBP, VTOTAL=VDISP+VFP+VPULSE+VBP, XW=$clog2(HDISP), YW=$clog2(VDISP)

Ports:
- fpga_CLK_AUX  in  1  video clock, 27 MHz, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- enable  in  1  run request; start and stop only on frame boundaries
- vid_HS  out  1  horizontal sync, active low
- vid_VS  out  1  vertical sync, active low
- vid_DE  out  1  display enable, active high
- vid_X  out  XW  pixel column; 0 when vid_DE=0
- vid_Y  out  YW  pixel row; 0 when vid_DE=0
- frame_start  out  1  one-cycle pulse on first active pixel of a frame
- line_req  out  1  request to prefetch line line_num
- line_num  out  YW  line index requested; stable while line_req=1
- line_ack  in  1  frame-buffer acknowledge of line_req
- underrun  out  1  sticky: a line request missed its deadline

## Operation
- Internal counters: hcnt 0..HTOTAL-1 wraps to 0, then vcnt increments; vcnt 0..VTOTAL-1 wraps to 0.
- Region order, horizontal and vertical: display, front porch, sync, back porch.
- FSM states:
  - IDLE: counters held at 0; enable=1 sampled -> RUN.
  - RUN: counters advance every cycle; enable=0 sampled -> DRAIN.
  - DRAIN: counters advance; at hcnt=HTOTAL-1 and vcnt=VTOTAL-1 -> IDLE. If enable=1 is sampled in DRAIN, the FSM returns to RUN with no discontinuity.
- In IDLE, outputs take their reset values, except that underrun holds.
- Decode on counters, registered to outputs:
  - DE = hcnt<HDISP && vcnt<VDISP
  - HS low for hcnt in [HDISP+HFP, HDISP+HFP+HPULSE-1]
  - VS low for vcnt in [VDISP+VFP, VDISP+VFP+VPULSE-1], switching only at hcnt=0
- Line request:
  - Issue condition: hcnt=HDISP and either (vcnt<VDISP-1, line_num=vcnt+1) or (vcnt=VTOTAL-1, line_num=0). No request otherwise.
  - line_req is held until line_ack is sampled high, then drops the next cycle.
  - line_ack is ignored while line_req=0.
- Deadline: if line_req is still high at hcnt=HTOTAL-1 and line_ack=0 that cycle, line_req drops the next cycle and underrun sets. Raster timing is unaffected.
- underrun clears only on reset or on the IDLE->RUN transition.
- Reset mid-operation: all outputs go immediately to reset values and the FSM goes to IDLE.

## Timing
- Reset values: vid_HS=1, vid_VS=1, vid_DE=0, vid_X=0, vid_Y=0, frame_start=0, line_req=0, line_num=0, underrun=0.
- All outputs are registered, with one cycle of latency from counter state to pins.
- Start latency: enable sampled high in IDLE -> counters at 0 next cycle -> frame_start=1 with vid_DE=1, vid_X=0, vid_Y=0 one cycle later.
- Frame period is HTOTAL*VTOTAL cycles (858*525 = 450450 at defaults, i.e. 59.94 Hz).
- line_req and line_num become valid one cycle after hcnt=HDISP, aligned with the first front-porch output cycle.
- Maximum line_req high time is HFP+HPULSE+HBP cycles.

## Test plan
All scenarios use HDISP=8, HFP=2, HPULSE=3, HBP=2, VDISP=4, VFP=1, VPULSE=2, VBP=1, giving HTOTAL=15, VTOTAL=8 and a 120-cycle frame.

1. Idle after reset:
   - Stimulus: n_rst low, then enable=0 for 50 cycles.
   - Required: vid_HS=1, vid_VS=1, vid_DE=0, line_req=0, underrun=0 throughout.
2. Raster with line_ack tied 1:
   - Timing: frame_start every 120 cycles, 2 cycles after enable; per frame vid_DE high 8 cycles per line on 4 lines (32 cycles).
   - Sync: vid_HS low 3 cycles, starting 10 cycles after each vid_DE rise; vid_VS low 30 cycles; vid_X steps 0..7 in each line.
3. Request sequencing with line_ack returned 4 cycles after line_req rises:
   - line_req issued on lines 0, 1, 2 (line_num 1, 2, 3) and on line 7 (line_num 0), each high exactly 5 cycles.
   - No line_req issued on lines 3..6.
4. Underrun with line_ack held 0:
   - Each line_req is high exactly 7 cycles.
   - underrun=1 from the first deadline onward; sync/DE timing is identical to scenario 2.
   - A re-enable after IDLE clears underrun.
5. Stop mid-frame: enable dropped during line 1.
   - The frame completes through line 7 (lines 2 and 3 still display), then IDLE with idle outputs.
   - Re-asserting enable yields frame_start 2 cycles later.
6. Async reset during line 2 with line_req high:
   - All outputs take reset values before the next clock edge, and underrun clears.
   - The FSM stays in IDLE until enable is sampled high after reset release.
